line_burst_adapter: RTL and testbench
=====================================

Name: line_burst_adapter

Overview:
- Memory-side responder for the cache-line request interface driven by the I/D-cache arbiter.
- Accepts one full-line read or write (LINE_W bits), holds the request handshake until done, and answers with a single-cycle line response.
- Converts each line transfer into an in-order burst of BEATS = LINE_W/BEAT_W beats on a narrow physical-memory port.
- Sits between the arbiter and the DRAM/memory model.

Parameters:
- LINE_W, 256, cache line width in bits; must be an integer multiple of BEAT_W.
- BEAT_W, 64, memory beat width in bits.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- line_address_i  in  ADDR_W  line request byte address (from arbiter).
- line_wdata_i  in  LINE_W  write line data.
- line_read_i  in  1  line read request; held high until line_resp_o.
- line_write_i  in  1  line write request; held high until line_resp_o.
- line_resp_o  out  1  one-cycle completion pulse.
- line_rdata_o  out  LINE_W  assembled read line; valid while line_resp_o=1.
- mem_address_o  out  ADDR_W  line-aligned burst address.
- mem_read_o  out  1  burst read request.
- mem_write_o  out  1  burst write request.
- mem_wdata_o  out  BEAT_W  current write beat.
- mem_rdata_i  in  BEAT_W  read beat data.
- mem_resp_i  in  1  per-beat acknowledge.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; beat counter = 0.
  - Line buffer and latched address cleared to 0.
  - All outputs 0.
  - Applies mid-burst too: the burst is abandoned with no line_resp_o.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - On a posedge with line_read_i=1: latch line_address_i with the low log2(LINE_W/8) bits forced to 0; go to RD_BURST.
  - Else if line_write_i=1: latch the address the same way, latch line_wdata_i into the buffer, go to WR_BURST.
  - Read and write both high is illegal; read wins.
  - mem_resp_i is ignored in IDLE and in both DONE states.
- RD_BURST:
  - mem_read_o=1 and mem_address_o = latched address, held stable for the whole burst.
  - Each cycle with mem_resp_i=1 writes mem_rdata_i into buffer bits [k*BEAT_W +: BEAT_W] and increments k.
  - Gaps (mem_resp_i=0) are allowed; k holds.
  - On the cycle the beat with k=BEATS-1 is sampled, go to RD_DONE; mem_read_o drops on the next cycle.
- RD_DONE:
  - line_resp_o=1 for exactly one cycle; line_rdata_o = buffer.
  - k resets to 0; go to IDLE.
- WR_BURST:
  - mem_write_o=1 with stable address; mem_wdata_o = buffer[k*BEAT_W +: BEAT_W].
  - k advances on mem_resp_i; after the last beat go to WR_DONE.
- WR_DONE: line_resp_o=1 for one cycle; go to IDLE.
- line_rdata_o is 0 whenever line_resp_o=0.
- Latency: line_resp_o asserts in the cycle after the last beat's mem_resp_i. With zero-wait memory, a read completes BEATS+2 cycles after the request is first seen in IDLE.
- Back-to-back: the requester drops its request after the response edge; the adapter is in IDLE on that cycle and accepts a new request on the following edge. There is no extra dead cycle beyond IDLE.
- Beat counter width is log2(BEATS); wrap after BEATS-1 occurs only through the DONE state reset.

Optional Feature:
- Macro: LINE_RESP_FASTPATH_EN.
- When defined:
  - RD_DONE and WR_DONE are removed.
  - line_resp_o is asserted combinationally in the same cycle the last beat's mem_resp_i=1 is seen.
  - line_rdata_o = buffer with the top slice replaced by the live mem_rdata_i.
  - The FSM returns directly to IDLE; latency drops by one cycle.
- When undefined: registered DONE-state response as described above.

Test Plan:
- Read, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles -> mem_address_o=0x0000_1220; line_resp_o one pulse; line_rdata_o = {0x44..,0x33..,0x22..,0x11..}; total 6 cycles.
- Read with mem_resp_i gaps (beats at cycles 1,3,4,7) -> same data assembly; mem_read_o high until the 4th beat; exactly one line_resp_o.
- Write, line_wdata_i = {0xDD..,0xCC..,0xBB..,0xAA..} -> mem_wdata_o presents 0xAA.., 0xBB.., 0xCC.., 0xDD.. in order, advancing only on mem_resp_i; then one line_resp_o.
- Write then immediate read -> the second request is accepted in the IDLE cycle after the write response; no overlap of mem_write_o and mem_read_o.
- rst_n low after 2 read beats -> outputs 0 immediately; no line_resp_o; a fresh read afterwards assembles correctly from beat 0.
- Stray mem_resp_i in IDLE plus simultaneous line_read_i and line_write_i -> stray beat ignored; read burst performed; no write issued.

Source files
------------

// File: rtl/line_burst_adapter.sv
// line_burst_adapter: memory-side responder for cache-line requests.
// Splits each full-line read or write into an in-order burst of LINE_W/BEAT_W
// beats on a narrow memory port and answers with a single-cycle line response.
// Optional macro LINE_RESP_FASTPATH_EN: the response is raised combinationally
// on the last beat's acknowledge instead of from a registered DONE state.
module line_burst_adapter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] line_address_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  input  logic              line_read_i,
  input  logic              line_write_i,
  output logic              line_resp_o,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

`ifdef LINE_RESP_FASTPATH_EN
  typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRdBurst, StRdDone, StWrBurst, StWrDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // State, beat counter, line buffer and latched line address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic, beat assembly/selection and all outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    addr_d        = addr_q;
    line_resp_o   = 1'b0;
    line_rdata_o  = '0;
    mem_address_o = '0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_wdata_o   = '0;

    unique case (state_q)
      StIdle: begin
        // Read wins if both requests are (illegally) raised together.
        if (line_read_i) begin
          addr_d              = line_address_i;
          addr_d[OFF_W-1:0]   = '0;
          state_d             = StRdBurst;
        end else if (line_write_i) begin
          addr_d              = line_address_i;
          addr_d[OFF_W-1:0]   = '0;
          buf_d               = line_wdata_i;
          state_d             = StWrBurst;
        end
      end

      StRdBurst: begin
        mem_read_o    = 1'b1;
        mem_address_o = addr_q;
        if (mem_resp_i) begin
          buf_d[cnt_q*BEAT_W +: BEAT_W] = mem_rdata_i;
          if (cnt_q == LastBeat) begin
`ifdef LINE_RESP_FASTPATH_EN
            // buf_d already carries the live last beat in its top slice.
            line_resp_o  = 1'b1;
            line_rdata_o = buf_d;
            cnt_d        = '0;
            state_d      = StIdle;
`else
            state_d      = StRdDone;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      StWrBurst: begin
        mem_write_o   = 1'b1;
        mem_address_o = addr_q;
        mem_wdata_o   = buf_q[cnt_q*BEAT_W +: BEAT_W];
        if (mem_resp_i) begin
          if (cnt_q == LastBeat) begin
`ifdef LINE_RESP_FASTPATH_EN
            line_resp_o = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
`else
            state_d     = StWrDone;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

`ifndef LINE_RESP_FASTPATH_EN
      StRdDone: begin
        line_resp_o  = 1'b1;
        line_rdata_o = buf_q;
        cnt_d        = '0;
        state_d      = StIdle;
      end

      StWrDone: begin
        line_resp_o = 1'b1;
        cnt_d       = '0;
        state_d     = StIdle;
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: directed test-plan cases plus
// randomized transactions against a line-level memory/requester model.
module tb_line_burst_adapter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEATS  = LINE_W / BEAT_W;
`ifdef LINE_RESP_FASTPATH_EN
  localparam int Extra = 0;
`else
  localparam int Extra = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] line_address = '0;
  logic [LINE_W-1:0] line_wdata = '0;
  logic              line_read = 1'b0;
  logic              line_write = 1'b0;
  logic              line_resp_o;
  logic [LINE_W-1:0] line_rdata_o;
  logic [ADDR_W-1:0] mem_address_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [BEAT_W-1:0] mem_wdata_o;
  logic [BEAT_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  line_burst_adapter #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_address_i(line_address),
    .line_wdata_i  (line_wdata),
    .line_read_i   (line_read),
    .line_write_i  (line_write),
    .line_resp_o   (line_resp_o),
    .line_rdata_o  (line_rdata_o),
    .mem_address_o (mem_address_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata),
    .mem_resp_i    (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".resp"}, LINE_W'(line_resp_o), '0);
    chk({tag, ".rdata"}, line_rdata_o, '0);
    chk({tag, ".addr"}, LINE_W'(mem_address_o), '0);
    chk({tag, ".rd"}, LINE_W'(mem_read_o), '0);
    chk({tag, ".wr"}, LINE_W'(mem_write_o), '0);
    chk({tag, ".wdata"}, LINE_W'(mem_wdata_o), '0);
  endtask

  // One line transaction seen cycle by cycle. Cycle 0 is the IDLE cycle in
  // which the request is first presented. The memory returns slice k of
  // 'line' as the k-th read beat; a write must present slice k as beat k.
  // resp_mask bit c set = acknowledge a beat in cycle c (0 = random gaps).
  task automatic run_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] line, input logic [31:0] resp_mask,
                         input bit stray, input int exp_lat);
    int cyc = 0;
    int beats = 0;
    int resp_cyc = -1;
    bit done = 0;
    bit give;
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = addr & ~ADDR_W'(LINE_W / 8 - 1);
    while (!done && cyc < 100) begin
      @(negedge clk);
      line_read    = rd;
      line_write   = wr;
      line_address = addr;
      line_wdata   = line;
      mem_resp     = 1'b0;
      mem_rdata    = {$urandom, $urandom};
      give         = 1'b0;
      if (cyc == 0) mem_resp = stray;
      else if (beats < BEATS)
        give = (resp_mask != 0) ? ((cyc < 32) ? resp_mask[cyc] : 1'b1)
                                : ($urandom_range(0, 99) >= 35);
      if (give) begin
        mem_resp = 1'b1;
        if (rd) mem_rdata = line[beats*BEAT_W +: BEAT_W];
      end
      #1;
      chk("no_overlap", LINE_W'(mem_read_o & mem_write_o), '0);
      if (cyc == 0) begin
        chk("idle_rd", LINE_W'(mem_read_o), '0);
        chk("idle_wr", LINE_W'(mem_write_o), '0);
      end else if (beats < BEATS) begin
        chk("burst_rd", LINE_W'(mem_read_o), LINE_W'(rd));
        chk("burst_wr", LINE_W'(mem_write_o), LINE_W'(!rd && wr));
        chk("burst_addr", LINE_W'(mem_address_o), LINE_W'(exp_addr));
        if (!rd) chk("wbeat", LINE_W'(mem_wdata_o), LINE_W'(line[beats*BEAT_W +: BEAT_W]));
      end
      if (line_resp_o) begin
        chk("resp_after_last_beat", LINE_W'((beats == BEATS) || (give && beats == BEATS - 1)), 1);
        if (rd) chk("rdata", line_rdata_o, line);
        resp_cyc = cyc;
        done = 1;
      end else begin
        chk("rdata_zero", line_rdata_o, '0);
      end
      if (give) beats++;
      cyc++;
    end
    chk("resp_seen", LINE_W'(done), 1);
    if (exp_lat >= 0) chk("latency", LINE_W'(resp_cyc), LINE_W'(exp_lat));
    // The requester drops its request after the response edge.
    @(negedge clk);
    line_read  = 1'b0;
    line_write = 1'b0;
    mem_resp   = 1'b0;
    #1;
    chk("single_pulse", LINE_W'(line_resp_o), '0);
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    // Reset state.
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("post_reset_idle");

    // Zero-wait read.
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn(1, 0, 32'h0000_1234, l, 32'h1E, 0, 4 + Extra);
    // Read with gaps: beats at cycles 1,3,4,7.
    run_txn(1, 0, 32'h0000_1234, l, 32'h9A, 0, 7 + Extra);
    // Write with a gap, then an immediate read.
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    run_txn(0, 1, 32'h8000_007F, l, 32'h36, 0, 5 + Extra);
    run_txn(1, 0, 32'h0000_00E0, rand_line(), 32'h1E, 0, 4 + Extra);
    // Stray beat in IDLE, read and write both high: read wins.
    run_txn(1, 1, 32'hDEAD_BEEF, rand_line(), 32'h1E, 1, 4 + Extra);

    // Reset after two read beats.
    @(negedge clk);
    line_read = 1'b1;
    line_address = 32'h0000_4000;
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("pre_abort_rd", LINE_W'(mem_read_o), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    line_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_resp", LINE_W'(line_resp_o), '0);
    end
    rst_n = 1'b1;
    run_txn(1, 0, 32'h0000_4010, rand_line(), 32'h1E, 0, 4 + Extra);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 12; i++) begin
      bit r;
      r = $urandom_range(0, 1);
      run_txn(r, !r, $urandom, rand_line(), 0, $urandom_range(0, 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
